onn_convergence_monitor: RTL and testbench
==========================================

// Module: onn_convergence_monitor
// PURPOSE
//  Downstream of the 3x5 neuron bank. Consumes per-neuron state_changed flags and the
//  packed phase bus phi_out. Decides when the oscillator network has settled:
//  STABLE_CHECKS consecutive checks with no phase change. A run that exceeds
//  MAX_TICKS full_ticks ends as a timeout instead. On either end, the block captures a
//  phase snapshot and offers it to the host readout over a valid/ready handshake.
// PARAMETERS
//  N              15   number of neurons (bit i of state_changed = neuron i)
//  PW             4    phase width per neuron; neuron i at phi_in[(PW*i) +: PW]
//  STABLE_CHECKS  4    consecutive quiet checks required for convergence (>=1)
//  MAX_TICKS      200  full_tick budget per run before timeout (1..2**CNT_W-1)
//  CNT_W          8    width of iteration counter
// PORTS
//  sclk           in   1       system clock, all logic on rising edge
//  re             in   1       synchronous active-high reset
//  start          in   1       1-cycle pulse: begin a new run (honoured only in IDLE)
//  full_tick      in   1       1-cycle pulse, one per full oscillation period
//  state_cheak    in   1       1-cycle pulse; state_changed is valid this cycle
//  state_changed  in   [0:N-1] per-neuron "phase changed since last check" flags
//  phi_in         in   [0:N*PW-1] packed live neuron phases from the bank
//  busy           out  1       1 while in RUN
//  done_valid     out  1       result available; held until accepted
//  done_ready     in   1       host accepts result when done_valid & done_ready
//  converged      out  1       result flag: settled within budget
//  timed_out      out  1       result flag: budget exhausted without settling
//  iter_count     out  [CNT_W-1:0] full_ticks counted in current/last run
//  phase_out      out  [0:N*PW-1]  phase snapshot captured at the decision edge
// BEHAVIOUR
//  Reset (re=1 at an edge, any state): state=IDLE. busy, done_valid, converged,
//   timed_out = 0. iter_count = 0, phase_out = 0, stable_cnt = 0. re overrides all other inputs.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: start=1 -> RUN next edge. On that edge, clear iter_count, stable_cnt,
//   converged and timed_out. busy=1 from the following cycle. full_tick and
//   state_cheak are ignored in IDLE.
//  RUN, per edge:
//   - full_tick=1: iter_count += 1 (saturate at 2**CNT_W-1).
//   - state_cheak=1: if |state_changed then stable_cnt = 0; else stable_cnt += 1
//     (saturate at STABLE_CHECKS).
//   - conv_hit  = state_cheak & ~|state_changed & (stable_cnt == STABLE_CHECKS-1).
//   - tmo_hit   = full_tick & (iter_count == MAX_TICKS-1).
//   - conv_hit (priority, even if tmo_hit same cycle): phase_out <= phi_in,
//     converged <= 1, timed_out <= 0, -> DONE.
//   - else tmo_hit: phase_out <= phi_in, timed_out <= 1, -> DONE.
//   - iter_count still updates on the deciding edge, so it reports the final count.
//   - start in RUN is ignored.
//  DONE: busy=0, done_valid=1 (registered, first high the cycle after decision edge).
//   phase_out, converged, timed_out and iter_count are held stable while done_valid=1.
//   done_valid & done_ready at an edge -> IDLE; done_valid=0 next cycle.
//   Result flags and phase_out persist in IDLE until the next start.
//   start in DONE is ignored, including in the accept cycle.
//  Latency: decision edge -> done_valid high 1 cycle later. phase_out = phi_in as
//   sampled at the decision edge.
//  state_changed and phi_in are used only in cycles where state_cheak or a hit is
//   evaluated; no other qualification.
//  STABLE_CHECKS=1: the first quiet check converges.
//  Reset mid-RUN or mid-DONE: the run is abandoned and no result is offered.
// TESTING
//  T1 reset: assert re 2 cycles mid-RUN -> busy=0, done_valid=0, iter_count=0,
//   phase_out=0, flags 0.
//  T2 converge: start; 3 checks with state_changed=15'h0001, then 4 checks all-zero
//   with phi_in=60'h123456789ABCDEF -> converged=1, timed_out=0,
//   phase_out=60'h123456789ABCDEF, done_valid 1 cycle after the 4th quiet check.
//  T3 reset-of-streak: quiet,quiet,quiet,change(bit14),quiet x4 -> converge only
//   on the 8th check.
//  T4 timeout: MAX_TICKS=200, start, 200 full_ticks, every check has a change ->
//   timed_out=1, converged=0, iter_count=200.
//  T5 simultaneous: 4th quiet check coincides with the 200th full_tick -> converged=1,
//   timed_out=0, iter_count=200.
//  T6 handshake: hold done_ready=0 for 10 cycles -> outputs stable; start pulses
//   ignored; then done_ready=1 -> IDLE next edge; new start clears flags and begins RUN.

Source files
------------

// File: rtl/onn_convergence_monitor.sv
// Convergence monitor for the oscillator neuron bank: detects a settled phase pattern
// or an exhausted tick budget, snapshots the phases and offers them over valid/ready.
module onn_convergence_monitor #(
  parameter int N             = 15,
  parameter int PW            = 4,
  parameter int STABLE_CHECKS = 4,
  parameter int MAX_TICKS     = 200,
  parameter int CNT_W         = 8
) (
  input  logic              sclk,
  input  logic              re,
  input  logic              start,
  input  logic              full_tick,
  input  logic              state_cheak,
  input  logic [0:N-1]      state_changed,
  input  logic [0:N*PW-1]   phi_in,
  output logic              busy,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              converged,
  output logic              timed_out,
  output logic [CNT_W-1:0]  iter_count,
  output logic [0:N*PW-1]   phase_out
);

  localparam int SC_W = $clog2(STABLE_CHECKS + 1);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STABLE_CHECKS);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(STABLE_CHECKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MAX_TICKS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [SC_W-1:0] stable_cnt;
  logic            quiet;
  logic            conv_hit;
  logic            tmo_hit;

  // The check that completes the quiet streak decides in the same edge it is counted.
  always_comb begin
    quiet    = ~|state_changed;
    conv_hit = state_cheak & quiet & (stable_cnt == SC_LAST);
    tmo_hit  = full_tick & (iter_count == TMO_LAST);
  end

  // NOTE: every register is written with <= so all updates in an edge see pre-edge values.
  always_ff @(posedge sclk) begin
    if (re) begin
      // NOTE: phase_out is a plain register (not a memory), so it is reset like the flags.
      state      <= IDLE;
      busy       <= 1'b0;
      done_valid <= 1'b0;
      converged  <= 1'b0;
      timed_out  <= 1'b0;
      iter_count <= '0;
      stable_cnt <= '0;
      phase_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            iter_count <= '0;
            stable_cnt <= '0;
            converged  <= 1'b0;
            timed_out  <= 1'b0;
          end
        end

        RUN: begin
          if (full_tick && iter_count != CNT_MAX)
            iter_count <= iter_count + CNT_W'(1);

          if (state_cheak) begin
            if (!quiet)
              stable_cnt <= '0;
            else if (stable_cnt != SC_MAX)
              stable_cnt <= stable_cnt + SC_W'(1);
          end

          if (conv_hit) begin
            phase_out  <= phi_in;
            converged  <= 1'b1;
            timed_out  <= 1'b0;
            busy       <= 1'b0;
            done_valid <= 1'b1;
            state      <= DONE;
          end else if (tmo_hit) begin
            phase_out  <= phi_in;
            timed_out  <= 1'b1;
            busy       <= 1'b0;
            done_valid <= 1'b1;
            state      <= DONE;
          end
        end

        DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onn_convergence_monitor.sv
// Directed bench for onn_convergence_monitor: expected results are queued as each run is
// stimulated and compared when done_valid appears.
module tb_onn_convergence_monitor;

  localparam int N     = 15;
  localparam int PW    = 4;
  localparam int CNT_W = 8;

  typedef struct {
    logic              conv;
    logic              tmo;
    logic [CNT_W-1:0]  iter;
    logic [0:N*PW-1]   phase;
  } result_t;

  logic              sclk = 1'b0;
  logic              re = 1'b0;
  logic              start = 1'b0;
  logic              full_tick = 1'b0;
  logic              state_cheak = 1'b0;
  logic [0:N-1]      state_changed = '0;
  logic [0:N*PW-1]   phi_in = '0;
  logic              busy;
  logic              done_valid;
  logic              done_ready = 1'b0;
  logic              converged;
  logic              timed_out;
  logic [CNT_W-1:0]  iter_count;
  logic [0:N*PW-1]   phase_out;

  result_t sb[$];
  result_t last_exp;
  int vectors = 0;
  int miscompares = 0;

  onn_convergence_monitor dut (
    .sclk(sclk), .re(re), .start(start), .full_tick(full_tick),
    .state_cheak(state_cheak), .state_changed(state_changed), .phi_in(phi_in),
    .busy(busy), .done_valid(done_valid), .done_ready(done_ready),
    .converged(converged), .timed_out(timed_out), .iter_count(iter_count),
    .phase_out(phase_out)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge and outputs are sampled at the same point.
  task automatic cycle();
    @(posedge sclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic pulse_tick();
    full_tick = 1'b1;
    cycle();
    full_tick = 1'b0;
  endtask

  task automatic pulse_check(input logic [0:N-1] chg, input logic [0:N*PW-1] phi);
    state_cheak   = 1'b1;
    state_changed = chg;
    phi_in        = phi;
    cycle();
    state_cheak   = 1'b0;
    state_changed = '0;
  endtask

  task automatic push_exp(input logic c, input logic t, input logic [CNT_W-1:0] it,
                          input logic [0:N*PW-1] ph);
    result_t r;
    r.conv = c; r.tmo = t; r.iter = it; r.phase = ph;
    sb.push_back(r);
  endtask

  task automatic check_result(input string tag, input result_t e);
    check({tag, "_conv"},  converged,  e.conv);
    check({tag, "_tmo"},   timed_out,  e.tmo);
    check({tag, "_iter"},  iter_count, e.iter);
    check({tag, "_phase"}, phase_out,  e.phase);
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (done_valid !== 1'b1 && n < 50) begin
      cycle();
      n++;
    end
    check({tag, "_valid"}, done_valid, 1'b1);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_sbq"},   sb.size(), 1);
    if (sb.size() > 0) begin
      last_exp = sb.pop_front();
      check_result(tag, last_exp);
    end
  endtask

  task automatic accept(input string tag);
    done_ready = 1'b1;
    cycle();
    done_ready = 1'b0;
    check({tag, "_acc_valid"}, done_valid, 1'b0);
    check({tag, "_acc_busy"},  busy, 1'b0);
  endtask

  initial begin
    logic [0:N-1]    one_chg;
    logic [0:N-1]    b14_chg;
    logic [0:N*PW-1] phi_a;
    logic [0:N*PW-1] phi_t;

    one_chg = 15'h0001;
    b14_chg = '0;
    b14_chg[14] = 1'b1;
    phi_a = 60'h123456789ABCDEF;

    // Power-on reset
    re = 1'b1;
    cycle();
    cycle();
    re = 1'b0;
    check("rst_busy",  busy, 1'b0);
    check("rst_valid", done_valid, 1'b0);
    check("rst_conv",  converged, 1'b0);
    check("rst_tmo",   timed_out, 1'b0);
    check("rst_iter",  iter_count, 0);
    check("rst_phase", phase_out, 0);

    // Ticks and checks in IDLE are ignored
    pulse_tick();
    pulse_check('0, phi_a);
    check("idle_busy", busy, 1'b0);
    check("idle_iter", iter_count, 0);

    // T2: converge after a change streak then four quiet checks; snapshot is the 4th's phi
    pulse_start();
    check("t2_busy", busy, 1'b1);
    for (int i = 0; i < 5; i++) pulse_tick();
    for (int i = 0; i < 3; i++) pulse_check(one_chg, 60'hAAAAAAAAAAAAAAA);
    pulse_check('0, 60'h111111111111111);
    pulse_check('0, 60'h222222222222222);
    pulse_check('0, 60'h333333333333333);
    check("t2_early", done_valid, 1'b0);
    push_exp(1'b1, 1'b0, 8'd5, phi_a);
    pulse_check('0, phi_a);
    check("t2_lat", done_valid, 1'b1);
    wait_result("t2");
    accept("t2");
    check("t2_persist_phase", phase_out, phi_a);
    check("t2_persist_conv",  converged, 1'b1);

    // T1: reset held two cycles mid-RUN abandons the run
    pulse_start();
    check("t1_conv_clr", converged, 1'b0);
    for (int i = 0; i < 3; i++) pulse_tick();
    pulse_check('0, phi_a);
    re = 1'b1;
    cycle();
    cycle();
    re = 1'b0;
    check("t1_busy",  busy, 1'b0);
    check("t1_valid", done_valid, 1'b0);
    check("t1_conv",  converged, 1'b0);
    check("t1_tmo",   timed_out, 1'b0);
    check("t1_iter",  iter_count, 0);
    check("t1_phase", phase_out, 0);
    for (int i = 0; i < 6; i++) pulse_check('0, phi_a);
    check("t1_no_result", done_valid, 1'b0);

    // T3: a change on the 4th check restarts the streak; converge on the 8th check
    pulse_start();
    for (int i = 0; i < 3; i++) pulse_check('0, 60'h0F0F0F0F0F0F0F0);
    pulse_check(b14_chg, 60'h0F0F0F0F0F0F0F0);
    for (int i = 0; i < 3; i++) pulse_check('0, 60'h0F0F0F0F0F0F0F0);
    check("t3_early", done_valid, 1'b0);
    push_exp(1'b1, 1'b0, 8'd0, 60'hC0FFEE123456789);
    pulse_check('0, 60'hC0FFEE123456789);
    check("t3_lat", done_valid, 1'b1);
    wait_result("t3");
    accept("t3");

    // T4: timeout after 200 full_ticks, every check reporting a change
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      phi_t = 60'hFEDCBA987654321 ^ 60'(i);
      if (i == 199) begin
        check("t4_early", done_valid, 1'b0);
        push_exp(1'b0, 1'b1, 8'd200, phi_t);
      end
      full_tick = 1'b1;
      pulse_check(one_chg, phi_t);
      full_tick = 1'b0;
    end
    wait_result("t4");
    accept("t4");

    // T5: the 4th quiet check lands on the 200th full_tick; convergence wins
    pulse_start();
    for (int i = 0; i < 196; i++) pulse_tick();
    for (int i = 0; i < 4; i++) begin
      phi_t = 60'h5A5A5A5A5A5A5A5 + 60'(i);
      if (i == 3) begin
        check("t5_early", done_valid, 1'b0);
        push_exp(1'b1, 1'b0, 8'd200, phi_t);
      end
      full_tick = 1'b1;
      pulse_check('0, phi_t);
      full_tick = 1'b0;
    end
    wait_result("t5");

    // T6: result held while done_ready is low; start and run inputs ignored in DONE
    for (int i = 0; i < 10; i++) begin
      start       = i[0];
      full_tick   = 1'b1;
      state_cheak = 1'b1;
      phi_in      = 60'h999999999999999;
      cycle();
      check("t6_hold_valid", done_valid, 1'b1);
      check("t6_hold_busy",  busy, 1'b0);
      check_result("t6_hold", last_exp);
    end
    full_tick   = 1'b0;
    state_cheak = 1'b0;
    start       = 1'b1;
    accept("t6");
    start = 1'b0;
    check("t6_idle_conv", converged, 1'b1);
    pulse_start();
    check("t6_new_busy", busy, 1'b1);
    check("t6_new_conv", converged, 1'b0);
    check("t6_new_tmo",  timed_out, 1'b0);
    check("t6_new_iter", iter_count, 0);
    pulse_tick();
    pulse_tick();
    for (int i = 0; i < 3; i++) pulse_check('0, 60'h0);
    push_exp(1'b1, 1'b0, 8'd2, 60'h0DDBA11CAFE0BED);
    pulse_check('0, 60'h0DDBA11CAFE0BED);
    wait_result("t6_new");
    accept("t6_new");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
